// File: rtl/dispatch_scheduler_pkg.sv
// dispatch_pkg: shared defaults and encodings for the dispatch scheduler.
//   NUM_REGS_DEF / REG_W_DEF : default scoreboard size and register index width
//   state_e                  : issue controller states
//   unit_e                   : execution unit select (ALU / memory)
package dispatch_pkg;

   localparam int NUM_REGS_DEF = 32;
   localparam int REG_W_DEF    = 5;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DRAIN   = 2'd1,
      DRAINED = 2'd2
   } state_e;

   typedef enum logic {
      UNIT_ALU = 1'b0,
      UNIT_MEM = 1'b1
   } unit_e;

   function automatic unit_e unit_sel(input logic has_address);
      return has_address ? UNIT_MEM : UNIT_ALU;
   endfunction

endpackage

// File: rtl/dispatch_scheduler_if.sv
// dispatch_scheduler_if: bundles the queue-head, unit handshake, issue payload,
// writeback, drain and stall-counter signals of the dispatch scheduler.
//   master : scheduler side (drives pop/issue/drained/stall_cycles)
//   slave  : environment side (queue, execution units, writeback, control)
interface dispatch_scheduler_if #(
   parameter int REG_W       = 5,
   parameter int STALL_CNT_W = 16
);
   logic                   iq_valid;
   logic [3:0]             MajorOpcode_in;
   logic [REG_W-1:0]       Source1_in;
   logic [REG_W-1:0]       Source2_in;
   logic [REG_W-1:0]       Destination_in;
   logic                   HasAddress_in;
   logic                   iq_pop;
   logic                   iq_stall;
   logic                   alu_ready;
   logic                   mem_ready;
   logic                   alu_issue;
   logic                   mem_issue;
   logic [3:0]             issue_op;
   logic [REG_W-1:0]       issue_dest;
   logic                   wb_alu_valid;
   logic                   wb_mem_valid;
   logic [REG_W-1:0]       wb_alu_dest;
   logic [REG_W-1:0]       wb_mem_dest;
   logic                   drain_req;
   logic                   drained;
   logic [STALL_CNT_W-1:0] stall_cycles;

   modport master (
      input  iq_valid, MajorOpcode_in, Source1_in, Source2_in, Destination_in,
             HasAddress_in, alu_ready, mem_ready, wb_alu_valid, wb_mem_valid,
             wb_alu_dest, wb_mem_dest, drain_req,
      output iq_pop, iq_stall, alu_issue, mem_issue, issue_op, issue_dest,
             drained, stall_cycles
   );

   modport slave (
      output iq_valid, MajorOpcode_in, Source1_in, Source2_in, Destination_in,
             HasAddress_in, alu_ready, mem_ready, wb_alu_valid, wb_mem_valid,
             wb_alu_dest, wb_mem_dest, drain_req,
      input  iq_pop, iq_stall, alu_issue, mem_issue, issue_op, issue_dest,
             drained, stall_cycles
   );
endinterface

// File: rtl/dispatch_scheduler_reg_scoreboard.sv
// reg_scoreboard: per-register busy bits with one set port and two clear ports.
//   clk, reset          : clock, synchronous active-high reset
//   set_en_i/set_idx_i  : mark a destination busy (register 0 is ignored)
//   clr*_en_i/clr*_idx_i: writeback clears (ALU and memory)
//   rd*_idx_i/rd*_busy_o: busy lookup with this cycle's clears already applied
//   busy_next_o         : busy vector as it will be after this edge
module reg_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int REG_W    = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                set_en_i,
   input  logic [REG_W-1:0]    set_idx_i,
   input  logic                clr0_en_i,
   input  logic [REG_W-1:0]    clr0_idx_i,
   input  logic                clr1_en_i,
   input  logic [REG_W-1:0]    clr1_idx_i,
   input  logic [REG_W-1:0]    rd0_idx_i,
   input  logic [REG_W-1:0]    rd1_idx_i,
   input  logic [REG_W-1:0]    rd2_idx_i,
   output logic                rd0_busy_o,
   output logic                rd1_busy_o,
   output logic                rd2_busy_o,
   output logic [NUM_REGS-1:0] busy_next_o
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [NUM_REGS-1:0] busy_eff;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         set_mask[i] = set_en_i && (set_idx_i == REG_W'(i));
         clr_mask[i] = (clr0_en_i && (clr0_idx_i == REG_W'(i))) ||
                       (clr1_en_i && (clr1_idx_i == REG_W'(i)));
      end
      // Clears bypass into the read; a same-cycle set overrides its clear.
      busy_eff    = busy_q & ~clr_mask;
      busy_d      = busy_eff | set_mask;
      busy_d[0]   = 1'b0;
      busy_next_o = busy_d;
      rd0_busy_o  = busy_eff[rd0_idx_i];
      rd1_busy_o  = busy_eff[rd1_idx_i];
      rd2_busy_o  = busy_eff[rd2_idx_i];
   end

   always_ff @(posedge clk) begin
      if (reset) busy_q <= '0;
      else       busy_q <= busy_d;
   end

endmodule

// File: rtl/dispatch_scheduler.sv
// dispatch_scheduler: issues the instruction-queue head to the ALU or memory
// unit once it is hazard-free and the unit is ready, with a drain sequence and
// a saturating stall-cycle counter.
//   clk, reset : clock, synchronous active-high reset
//   bus        : dispatch_scheduler_if.master (queue head, unit ready/issue,
//                writebacks, drain_req/drained, stall_cycles)
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   RUN     | normal issue
//   DRAIN   | issue stopped, waiting for outstanding writebacks
//   DRAINED | idle with empty scoreboard, drained asserted
module dispatch_scheduler
   import dispatch_pkg::*;
#(
   parameter int NUM_REGS    = NUM_REGS_DEF,
   parameter int REG_W       = REG_W_DEF,
   parameter int STALL_CNT_W = 16
) (
   input logic                 clk,
   input logic                 reset,
   dispatch_scheduler_if.master bus
);

   state_e                 state_q, state_d;
   logic                   alu_issue_q, alu_issue_d;
   logic                   mem_issue_q, mem_issue_d;
   logic [3:0]             issue_op_q, issue_op_d;
   logic [REG_W-1:0]       issue_dest_q, issue_dest_d;
   logic                   drained_q, drained_d;
   logic [STALL_CNT_W-1:0] stall_q, stall_d;

   logic                   pop;
   logic                   hazard;
   logic                   unit_ok;
   logic                   rd0_busy, rd1_busy, rd2_busy;
   logic [NUM_REGS-1:0]    busy_next;

   reg_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .REG_W    (REG_W)
   ) u_sb (
      .clk         (clk),
      .reset       (reset),
      .set_en_i    (pop),
      .set_idx_i   (bus.Destination_in),
      .clr0_en_i   (bus.wb_alu_valid),
      .clr0_idx_i  (bus.wb_alu_dest),
      .clr1_en_i   (bus.wb_mem_valid),
      .clr1_idx_i  (bus.wb_mem_dest),
      .rd0_idx_i   (bus.Source1_in),
      .rd1_idx_i   (bus.Source2_in),
      .rd2_idx_i   (bus.Destination_in),
      .rd0_busy_o  (rd0_busy),
      .rd1_busy_o  (rd1_busy),
      .rd2_busy_o  (rd2_busy),
      .busy_next_o (busy_next)
   );

   always_comb begin
      hazard  = rd0_busy | rd1_busy | rd2_busy;
      unit_ok = bus.HasAddress_in ? bus.mem_ready : bus.alu_ready;
      // A drain request blocks the pop in the very cycle it arrives.
      pop     = (state_q == RUN) & ~bus.drain_req & bus.iq_valid & ~hazard & unit_ok;
   end

   always_comb begin
      state_d      = state_q;
      alu_issue_d  = 1'b0;
      mem_issue_d  = 1'b0;
      issue_op_d   = issue_op_q;
      issue_dest_d = issue_dest_q;
      stall_d      = stall_q;

      if (pop) begin
         alu_issue_d  = (unit_sel(bus.HasAddress_in) == UNIT_ALU);
         mem_issue_d  = (unit_sel(bus.HasAddress_in) == UNIT_MEM);
         issue_op_d   = bus.MajorOpcode_in;
         issue_dest_d = bus.Destination_in;
      end

      if ((state_q == RUN) && bus.iq_valid && !pop && (stall_q != '1)) begin
         stall_d = stall_q + 1'b1;
      end

      unique case (state_q)
         RUN: begin
            if (bus.drain_req) state_d = DRAIN;
         end
         DRAIN: begin
            if (!bus.drain_req) begin
               state_d = RUN;
            end else if ((busy_next == '0) && !alu_issue_q && !mem_issue_q) begin
               state_d = DRAINED;
            end
         end
         DRAINED: begin
            if (!bus.drain_req) state_d = RUN;
         end
         default: state_d = RUN;
      endcase

      drained_d = (state_d == DRAINED);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= RUN;
         alu_issue_q  <= 1'b0;
         mem_issue_q  <= 1'b0;
         issue_op_q   <= '0;
         issue_dest_q <= '0;
         drained_q    <= 1'b0;
         stall_q      <= '0;
      end else begin
         state_q      <= state_d;
         alu_issue_q  <= alu_issue_d;
         mem_issue_q  <= mem_issue_d;
         issue_op_q   <= issue_op_d;
         issue_dest_q <= issue_dest_d;
         drained_q    <= drained_d;
         stall_q      <= stall_d;
      end
   end

   assign bus.iq_pop       = pop;
   assign bus.iq_stall     = ~pop;
   assign bus.alu_issue    = alu_issue_q;
   assign bus.mem_issue    = mem_issue_q;
   assign bus.issue_op     = issue_op_q;
   assign bus.issue_dest   = issue_dest_q;
   assign bus.drained      = drained_q;
   assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_dispatch_scheduler.sv
// tb_dispatch_scheduler: directed bench for dispatch_scheduler with a 4-bit
// stall counter; expected values are hand-derived per step.
module tb_dispatch_scheduler;

   logic clk;
   logic reset;
   int   n_pass;
   int   n_total;

   dispatch_scheduler_if #(.REG_W(5), .STALL_CNT_W(4)) bus ();

   dispatch_scheduler #(
      .NUM_REGS    (32),
      .REG_W       (5),
      .STALL_CNT_W (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic head(input logic v, input logic [3:0] op, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [4:0] d, input logic mem);
      bus.iq_valid       = v;
      bus.MajorOpcode_in = op;
      bus.Source1_in     = s1;
      bus.Source2_in     = s2;
      bus.Destination_in = d;
      bus.HasAddress_in  = mem;
   endtask

   task automatic wb(input logic av, input logic [4:0] ad, input logic mv, input logic [4:0] md);
      bus.wb_alu_valid = av;
      bus.wb_alu_dest  = ad;
      bus.wb_mem_valid = mv;
      bus.wb_mem_dest  = md;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      reset   = 1'b1;
      head(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      wb(1'b0, 5'd0, 1'b0, 5'd0);
      bus.alu_ready = 1'b0;
      bus.mem_ready = 1'b0;
      bus.drain_req = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      settle();

      // Reset state
      chk("rst_alu_issue", 32'(bus.alu_issue), 32'd0);
      chk("rst_mem_issue", 32'(bus.mem_issue), 32'd0);
      chk("rst_issue_op", 32'(bus.issue_op), 32'd0);
      chk("rst_issue_dest", 32'(bus.issue_dest), 32'd0);
      chk("rst_drained", 32'(bus.drained), 32'd0);
      chk("rst_stall", 32'(bus.stall_cycles), 32'd0);
      chk("rst_pop_empty", 32'(bus.iq_pop), 32'd0);
      chk("rst_iq_stall", 32'(bus.iq_stall), 32'd1);

      // Independent stream: 4 ALU ops on dests 1..4
      bus.alu_ready = 1'b1;
      bus.mem_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         head(1'b1, 4'(i + 1), 5'd0, 5'd0, 5'(i), 1'b0);
         settle();
         chk($sformatf("stream_pop_%0d", i), 32'(bus.iq_pop), 32'd1);
         chk($sformatf("stream_iq_stall_%0d", i), 32'(bus.iq_stall), 32'd0);
         tick();
         chk($sformatf("stream_alu_issue_%0d", i), 32'(bus.alu_issue), 32'd1);
         chk($sformatf("stream_mem_issue_%0d", i), 32'(bus.mem_issue), 32'd0);
         chk($sformatf("stream_dest_%0d", i), 32'(bus.issue_dest), 32'(i));
         chk($sformatf("stream_op_%0d", i), 32'(bus.issue_op), 32'(i + 1));
      end
      head(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      wb(1'b1, 5'd1, 1'b1, 5'd2);
      tick();
      chk("stream_alu_issue_end", 32'(bus.alu_issue), 32'd0);
      chk("stream_stall", 32'(bus.stall_cycles), 32'd0);
      wb(1'b1, 5'd3, 1'b1, 5'd4);
      tick();
      wb(1'b0, 5'd0, 1'b0, 5'd0);

      // RAW hazard: A dest 5, then B src1 5
      head(1'b1, 4'h3, 5'd0, 5'd0, 5'd5, 1'b0);
      settle();
      chk("raw_a_pop", 32'(bus.iq_pop), 32'd1);
      tick();
      chk("raw_a_issue_dest", 32'(bus.issue_dest), 32'd5);
      head(1'b1, 4'h4, 5'd5, 5'd0, 5'd6, 1'b0);
      settle();
      chk("raw_b_held_1", 32'(bus.iq_pop), 32'd0);
      tick();
      settle();
      chk("raw_b_held_2", 32'(bus.iq_pop), 32'd0);
      tick();
      wb(1'b1, 5'd5, 1'b0, 5'd0);
      settle();
      chk("raw_b_bypass_pop", 32'(bus.iq_pop), 32'd1);
      tick();
      wb(1'b0, 5'd0, 1'b0, 5'd0);
      head(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      chk("raw_b_issue", 32'(bus.alu_issue), 32'd1);
      chk("raw_b_dest", 32'(bus.issue_dest), 32'd6);
      chk("raw_stall", 32'(bus.stall_cycles), 32'd2);
      wb(1'b1, 5'd6, 1'b0, 5'd0);
      tick();
      wb(1'b0, 5'd0, 1'b0, 5'd0);

      // Unit busy: memory op with mem_ready low for 3 cycles
      bus.mem_ready = 1'b0;
      head(1'b1, 4'h9, 5'd0, 5'd0, 5'd8, 1'b1);
      for (int i = 0; i < 3; i++) begin
         settle();
         chk($sformatf("unit_wait_pop_%0d", i), 32'(bus.iq_pop), 32'd0);
         tick();
         chk($sformatf("unit_wait_mem_%0d", i), 32'(bus.mem_issue), 32'd0);
      end
      bus.mem_ready = 1'b1;
      settle();
      chk("unit_pop", 32'(bus.iq_pop), 32'd1);
      tick();
      head(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      chk("unit_mem_issue", 32'(bus.mem_issue), 32'd1);
      chk("unit_alu_quiet", 32'(bus.alu_issue), 32'd0);
      chk("unit_op", 32'(bus.issue_op), 32'd9);
      chk("unit_dest", 32'(bus.issue_dest), 32'd8);
      wb(1'b0, 5'd0, 1'b1, 5'd8);
      tick();
      wb(1'b0, 5'd0, 1'b0, 5'd0);
      chk("unit_mem_once", 32'(bus.mem_issue), 32'd0);
      chk("unit_stall", 32'(bus.stall_cycles), 32'd5);

      // Set/clear collision on register 7
      head(1'b1, 4'h1, 5'd0, 5'd0, 5'd7, 1'b0);
      tick();
      wb(1'b1, 5'd7, 1'b0, 5'd0);
      settle();
      chk("coll_pop", 32'(bus.iq_pop), 32'd1);
      tick();
      wb(1'b0, 5'd0, 1'b0, 5'd0);
      head(1'b1, 4'h2, 5'd7, 5'd0, 5'd9, 1'b0);
      settle();
      chk("coll_r7_still_busy", 32'(bus.iq_pop), 32'd0);
      tick();
      wb(1'b1, 5'd7, 1'b0, 5'd0);
      settle();
      chk("coll_r7_cleared_pop", 32'(bus.iq_pop), 32'd1);
      tick();
      head(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      wb(1'b1, 5'd9, 1'b0, 5'd0);
      tick();
      wb(1'b0, 5'd0, 1'b0, 5'd0);
      chk("coll_stall", 32'(bus.stall_cycles), 32'd6);

      // Destination 0 never becomes busy
      head(1'b1, 4'h5, 5'd0, 5'd0, 5'd0, 1'b0);
      settle();
      chk("r0_pop_1", 32'(bus.iq_pop), 32'd1);
      tick();
      chk("r0_issue_dest", 32'(bus.issue_dest), 32'd0);
      chk("r0_pop_2", 32'(bus.iq_pop), 32'd1);
      tick();
      head(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();

      // Drain with two ops in flight
      head(1'b1, 4'h6, 5'd0, 5'd0, 5'd10, 1'b0);
      tick();
      head(1'b1, 4'h7, 5'd0, 5'd0, 5'd11, 1'b1);
      tick();
      head(1'b1, 4'h8, 5'd0, 5'd0, 5'd12, 1'b0);
      bus.drain_req = 1'b1;
      settle();
      chk("drain_req_blocks_pop", 32'(bus.iq_pop), 32'd0);
      tick();
      wb(1'b1, 5'd10, 1'b0, 5'd0);
      settle();
      chk("drain_no_pop_1", 32'(bus.iq_pop), 32'd0);
      chk("drain_not_done_1", 32'(bus.drained), 32'd0);
      tick();
      wb(1'b0, 5'd0, 1'b0, 5'd0);
      chk("drain_not_done_2", 32'(bus.drained), 32'd0);
      tick();
      wb(1'b0, 5'd0, 1'b1, 5'd11);
      chk("drain_not_done_3", 32'(bus.drained), 32'd0);
      tick();
      wb(1'b0, 5'd0, 1'b0, 5'd0);
      chk("drained_rise", 32'(bus.drained), 32'd1);
      chk("drained_no_pop", 32'(bus.iq_pop), 32'd0);
      tick();
      chk("drained_hold", 32'(bus.drained), 32'd1);
      bus.drain_req = 1'b0;
      settle();
      chk("drained_release_no_pop", 32'(bus.iq_pop), 32'd0);
      tick();
      chk("drained_fall", 32'(bus.drained), 32'd0);
      chk("resume_pop", 32'(bus.iq_pop), 32'd1);
      tick();
      head(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      chk("resume_issue", 32'(bus.alu_issue), 32'd1);
      chk("resume_dest", 32'(bus.issue_dest), 32'd12);
      chk("drain_stall", 32'(bus.stall_cycles), 32'd7);

      // Saturation: hold hazard on r12 for 12 cycles (7 + 12 > 15)
      head(1'b1, 4'hA, 5'd12, 5'd0, 5'd13, 1'b0);
      for (int i = 0; i < 12; i++) tick();
      chk("sat_value", 32'(bus.stall_cycles), 32'd15);
      tick();
      chk("sat_hold", 32'(bus.stall_cycles), 32'd15);

      // Reset in the cycle of a pop discards the issue and clears the scoreboard
      wb(1'b1, 5'd12, 1'b0, 5'd0);
      settle();
      chk("rst_mid_pop", 32'(bus.iq_pop), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wb(1'b0, 5'd0, 1'b0, 5'd0);
      head(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      chk("rst_mid_alu_issue", 32'(bus.alu_issue), 32'd0);
      chk("rst_mid_mem_issue", 32'(bus.mem_issue), 32'd0);
      chk("rst_mid_op", 32'(bus.issue_op), 32'd0);
      chk("rst_mid_dest", 32'(bus.issue_dest), 32'd0);
      chk("rst_mid_stall", 32'(bus.stall_cycles), 32'd0);
      chk("rst_mid_drained", 32'(bus.drained), 32'd0);
      head(1'b1, 4'hB, 5'd13, 5'd12, 5'd14, 1'b0);
      settle();
      chk("rst_busy_cleared", 32'(bus.iq_pop), 32'd1);
      tick();
      head(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      chk("post_rst_issue", 32'(bus.alu_issue), 32'd1);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
